uart_tx: RTL and testbench



---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_baud_gen.sv | 27 ++
 rtl/uart_tx.sv | 113 +++++++++++
 tb/tb_uart_tx.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: divisor table, baud select decode and TX state encoding
// shared by the UART transmit and receive paths.
package uart_pkg;

    localparam int unsigned DIV_W = 13;

    localparam logic [DIV_W-1:0] BPS_115200 = 13'd434;
    localparam logic [DIV_W-1:0] BPS_57600  = 13'd868;
    localparam logic [DIV_W-1:0] BPS_38400  = 13'd1302;
    localparam logic [DIV_W-1:0] BPS_19200  = 13'd2604;
    localparam logic [DIV_W-1:0] BPS_9600   = 13'd5208;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // Unused select codes fall back to the fastest rate.
    function automatic logic [DIV_W-1:0] baud_div(input logic [2:0] sel);
        logic [DIV_W-1:0] d;
        case (sel)
            3'd1:    d = BPS_57600;
            3'd2:    d = BPS_38400;
            3'd3:    d = BPS_19200;
            3'd4:    d = BPS_9600;
            default: d = BPS_115200;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter, 0..div-1, tick in the last
// cycle of each bit period.
module uart_baud_gen
    import uart_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    assign tick = (cnt == (div - 13'd1));

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 13'd1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter, LSB first, idle-high line, with a
// one-entry holding register so frames can run back to back.
module uart_tx
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] baud_set,
    input  logic [7:0] tx_din,
    input  logic       tx_vld,
    output logic       tx_rdy,
    output logic       dout,
    output logic       tx_busy,
    output logic       tx_done
);

    tx_state_t        state;
    logic [7:0]       hold;
    logic [7:0]       shifter;
    logic             hold_full;
    logic [2:0]       bit_cnt;
    logic [DIV_W-1:0] div;
    logic             tick;
    logic             accept;
    logic             load;
    logic             cnt_clr;

    assign accept  = tx_vld && tx_rdy;
    assign cnt_clr = (state == IDLE);
    assign tx_done = (state == STOP) && tick;

    // A frame loads from idle, or straight out of a finished stop bit.
    assign load = hold_full &&
                  ((state == IDLE) || ((state == STOP) && tick));

    uart_baud_gen u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .div   (div),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            dout      <= 1'b1;
            tx_busy   <= 1'b0;
            tx_rdy    <= 1'b0;
            hold_full <= 1'b0;
            hold      <= '0;
            shifter   <= '0;
            bit_cnt   <= '0;
            div       <= BPS_115200;
        end else begin
            unique case (1'b1)
                accept: begin
                    hold      <= tx_din;
                    hold_full <= 1'b1;
                    tx_rdy    <= 1'b0;
                end
                load: begin
                    hold_full <= 1'b0;
                    tx_rdy    <= 1'b1;
                end
                default: tx_rdy <= ~hold_full;
            endcase

            if (load) begin
                state   <= START;
                dout    <= 1'b0;
                tx_busy <= 1'b1;
                shifter <= hold;
                bit_cnt <= '0;
                div     <= baud_div(baud_set);
            end else begin
                unique case (state)
                    IDLE: begin
                        dout    <= 1'b1;
                        tx_busy <= 1'b0;
                    end
                    START: begin
                        if (tick) begin
                            state   <= DATA;
                            dout    <= shifter[0];
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        if (tick) begin
                            if (bit_cnt == 3'd7) begin
                                state <= STOP;
                                dout  <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                                shifter <= shifter >> 1;
                                dout    <= shifter[1];
                            end
                        end
                    end
                    STOP: begin
                        if (tick) begin
                            state   <= IDLE;
                            tx_busy <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: random and directed frames checked against a line-level
// model of 8N1 framing built from byte, divisor and frame offset.
module tb_uart_tx;

    logic       clk;
    logic       rst_n;
    logic [2:0] baud_set;
    logic [7:0] tx_din;
    logic       tx_vld;
    logic       tx_rdy;
    logic       dout;
    logic       tx_busy;
    logic       tx_done;

    typedef struct {
        logic [7:0] data;
        int         div;
    } frame_t;

    frame_t exp_q[$];
    int     n_checks  = 0;
    int     n_errors  = 0;
    int     busy_cnt  = 0;
    bit     spur_seen = 0;

    uart_tx dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .baud_set (baud_set),
        .tx_din   (tx_din),
        .tx_vld   (tx_vld),
        .tx_rdy   (tx_rdy),
        .dout     (dout),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int div_of(input logic [2:0] bs);
        case (bs)
            3'd1:    return 868;
            3'd2:    return 1302;
            3'd3:    return 2604;
            3'd4:    return 5208;
            default: return 434;
        endcase
    endfunction

    function automatic logic frame_bit(input logic [7:0] d, input int k);
        logic [9:0] fr;
        fr = {1'b1, d, 1'b0};
        return fr[k];
    endfunction

    always @(negedge clk) if (tx_busy) busy_cnt++;

    // Line monitor: acts as the far-end receiver and timing checker.
    always begin : monitor
        frame_t     f;
        int         bad;
        int         dn;
        int         dn_at;
        int         k;
        logic [7:0] rx;
        bit         aborted;
        @(negedge clk);
        if (rst_n && dout === 1'b0) begin
            if (exp_q.size() == 0) begin
                if (!spur_seen) check("spurious_frame", 32'(dout), 1);
                spur_seen = 1;
            end else begin
                f       = exp_q.pop_front();
                bad     = 0;
                dn      = 0;
                dn_at   = -1;
                rx      = '0;
                aborted = 0;
                check("rdy_at_start", 32'(tx_rdy), 1);
                for (int off = 0; off < 10 * f.div; off++) begin
                    if (off > 0) @(negedge clk);
                    if (!rst_n) begin
                        aborted = 1;
                        break;
                    end
                    k = off / f.div;
                    if (dout !== frame_bit(f.data, k) || tx_busy !== 1'b1)
                        bad++;
                    if ((off % f.div) == f.div / 2 && k >= 1 && k <= 8)
                        rx[k-1] = dout;
                    if (tx_done) begin
                        dn++;
                        dn_at = off;
                    end
                end
                check("line_bits", 32'(bad), 0);
                if (!aborted) begin
                    check("rx_byte", 32'(rx), 32'(f.data));
                    check("done_count", 32'(dn), 1);
                    check("done_pos", 32'(dn_at), 32'(10 * f.div - 1));
                end
            end
        end
    end

    task automatic send(input logic [7:0] b);
        int n = 0;
        tx_din = b;
        tx_vld = 1'b1;
        while (!tx_rdy && n < 60000) begin
            @(negedge clk);
            n++;
        end
        check("send_timeout", 32'(n < 60000), 1);
        exp_q.push_back('{data: b, div: div_of(baud_set)});
        @(negedge clk);
        tx_vld = 1'b0;
        tx_din = 8'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((tx_busy || !tx_rdy) && n < 60000) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(n < 60000), 1);
    endtask

    task automatic reset_abort();
        int lows = 0;
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_dout", 32'(dout), 1);
        check("abort_busy", 32'(tx_busy), 0);
        check("abort_rdy", 32'(tx_rdy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("rdy_after_abort", 32'(tx_rdy), 1);
        repeat (1000) begin
            @(negedge clk);
            if (!dout) lows++;
        end
        check("no_residual", 32'(lows), 0);
        check("idle_after_abort", 32'(tx_busy), 0);
    endtask

    initial begin
        int b0;
        rst_n    = 1'b0;
        tx_vld   = 1'b0;
        tx_din   = '0;
        baud_set = '0;

        repeat (3) begin
            @(negedge clk);
            check("rst_dout", 32'(dout), 1);
            check("rst_rdy", 32'(tx_rdy), 0);
            check("rst_busy", 32'(tx_busy), 0);
            check("rst_done", 32'(tx_done), 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("rdy_after_rst", 32'(tx_rdy), 1);
        check("idle_dout", 32'(dout), 1);

        baud_set = 3'd0;
        send(8'hA5);
        check("rdy_after_accept", 32'(tx_rdy), 0);
        check("dout_before_start", 32'(dout), 1);
        @(negedge clk);
        check("start_latency", 32'(dout), 0);
        check("rdy_reload", 32'(tx_rdy), 1);
        check("busy_start", 32'(tx_busy), 1);
        wait_idle();
        check("end_dout", 32'(dout), 1);
        check("end_busy", 32'(tx_busy), 0);

        baud_set = 3'd1;
        b0 = busy_cnt;
        send(8'h55);
        send(8'h0F);
        wait_idle();
        check("b2b_busy_cycles", 32'(busy_cnt - b0), 17360);

        baud_set = 3'd2;
        send(8'hFF);
        wait_idle();

        baud_set = 3'd7;
        send(8'($urandom));
        wait_idle();

        baud_set = 3'd0;
        send(8'h00);
        wait_idle();

        baud_set = 3'd4;
        send(8'h3C);
        repeat (2 * 5208) @(negedge clk);
        baud_set = 3'd0;
        repeat (2 * 5208 + 2604 + 1) @(negedge clk);
        reset_abort();

        baud_set = 3'd3;
        send(8'($urandom));
        send(8'($urandom));
        repeat (4 * 2604 + 1302 - 1) @(negedge clk);
        check("hold_full_mid", 32'(tx_rdy), 0);
        reset_abort();

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
